// File: rtl/im_pkg.sv
// Shared definitions for the instruction-memory loader and the instruction memory.
package im_pkg;

  localparam int IM_DEPTH = 64;
  localparam int ADDR_W   = 6;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN,
    ST_LOAD,
    ST_CSUM,
    ST_FIN
  } im_state_e;

  // True when a byte address lands inside the instruction memory.
  function automatic logic addr_in_range(input int unsigned addr, input int unsigned depth);
    return addr < depth;
  endfunction

endpackage

// File: rtl/im_loader_if.sv
// Byte-stream source and instruction-memory write port of the loader.
// master: loader side; slave: source/memory side.
interface im_loader_if #(
  parameter int ADDR_W = im_pkg::ADDR_W
) ();

  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              im_we;
  logic [ADDR_W-1:0] im_waddr;
  logic [7:0]        im_wdata;

  modport master (
    input  in_valid, in_data,
    output in_ready, im_we, im_waddr, im_wdata
  );

  modport slave (
    output in_valid, in_data,
    input  in_ready, im_we, im_waddr, im_wdata
  );

endinterface

// File: rtl/im_loader.sv
// Streams a length-prefixed byte image into instruction memory while holding the CPU.
// Define IM_LOADER_CHECKSUM_EN to require a trailing mod-256 checksum byte.
module im_loader #(
  parameter int IM_DEPTH  = im_pkg::IM_DEPTH,
  parameter int ADDR_W    = im_pkg::ADDR_W,
  parameter int BASE_ADDR = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  im_loader_if.master bus,
  output logic        cpu_hold,
  output logic        busy,
  output logic        done,
  output logic        err
);

  import im_pkg::*;

  im_state_e         state_q, state_d;
  logic [7:0]        len_q, len_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [7:0]        wdata_q, wdata_d;
`ifdef IM_LOADER_CHECKSUM_EN
  logic [7:0]        sum_q, sum_d;
`endif

  logic              in_ready;
  logic              xfer;
  logic              last_byte;
  logic              in_range;
  logic [9:0]        full_addr;

  assign in_ready  = (state_q == ST_LEN) || (state_q == ST_LOAD) || (state_q == ST_CSUM);
  assign xfer      = bus.in_valid && in_ready;
  assign last_byte = (cnt_q == (len_q - 8'd1));

  // Wide enough to hold BASE_ADDR+255 so an overflowing address never wraps.
  assign full_addr = 10'(BASE_ADDR) + {2'b00, cnt_q};
  assign in_range  = addr_in_range(32'(full_addr), IM_DEPTH);

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = done_q;
    err_d   = err_q;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
`ifdef IM_LOADER_CHECKSUM_EN
    sum_d   = sum_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_LEN;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          err_d   = 1'b0;
          cnt_d   = 8'd0;
`ifdef IM_LOADER_CHECKSUM_EN
          sum_d   = 8'd0;
`endif
        end
      end

      ST_LEN: begin
        if (xfer) begin
          len_d = bus.in_data;
          cnt_d = 8'd0;
          if (bus.in_data == 8'd0) begin
`ifdef IM_LOADER_CHECKSUM_EN
            state_d = ST_CSUM;
`else
            state_d = ST_FIN;
`endif
          end else begin
            state_d = ST_LOAD;
          end
        end
      end

      ST_LOAD: begin
        if (xfer) begin
          if (in_range) begin
            we_d    = 1'b1;
            waddr_d = full_addr[ADDR_W-1:0];
            wdata_d = bus.in_data;
          end else begin
            err_d   = 1'b1;
          end
`ifdef IM_LOADER_CHECKSUM_EN
          sum_d = sum_q + bus.in_data;
`endif
          cnt_d = cnt_q + 8'd1;
          if (last_byte) begin
`ifdef IM_LOADER_CHECKSUM_EN
            state_d = ST_CSUM;
`else
            state_d = ST_FIN;
`endif
          end
        end
      end

      ST_CSUM: begin
`ifdef IM_LOADER_CHECKSUM_EN
        if (xfer) begin
          if (bus.in_data != sum_q) begin
            err_d = 1'b1;
          end
          state_d = ST_FIN;
        end
`else
        state_d = ST_IDLE;
`endif
      end

      ST_FIN: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      len_q   <= 8'd0;
      cnt_q   <= 8'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= 8'd0;
`ifdef IM_LOADER_CHECKSUM_EN
      sum_q   <= 8'd0;
`endif
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
`ifdef IM_LOADER_CHECKSUM_EN
      sum_q   <= sum_d;
`endif
    end
  end

  assign bus.in_ready = in_ready;
  assign bus.im_we    = we_q;
  assign bus.im_waddr = waddr_q;
  assign bus.im_wdata = wdata_q;
  assign busy         = busy_q;
  assign cpu_hold     = busy_q;
  assign done         = done_q;
  assign err          = err_q;

endmodule

// File: tb/tb_im_loader.sv
// Self-checking bench: two loaders (base 0 and base 62) share one byte stream;
// expected writes/err/done come from the stream contents, not from the FSM.
module tb_im_loader;

  typedef logic [7:0] bq_t[$];
  typedef struct packed {
    int         cyc;
    logic [5:0] addr;
    logic [7:0] data;
  } wr_t;

  localparam int BASE0 = 0;
  localparam int BASE1 = 62;
  localparam int DEPTH = 64;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic tb_valid;
  logic [7:0] tb_data;
  logic cpu_hold0, busy0, done0, err0;
  logic cpu_hold1, busy1, done1, err1;

  int checks   = 0;
  int failures = 0;
  int neg_cnt  = 0;

  wr_t act0[$], act1[$], exp0[$], exp1[$];

  always #5 clk = ~clk;

  im_loader_if #(.ADDR_W(6)) bus0 ();
  im_loader_if #(.ADDR_W(6)) bus1 ();

  assign bus0.in_valid = tb_valid;
  assign bus0.in_data  = tb_data;
  assign bus1.in_valid = tb_valid;
  assign bus1.in_data  = tb_data;

  im_loader #(.IM_DEPTH(DEPTH), .ADDR_W(6), .BASE_ADDR(BASE0)) dut0 (
    .clk(clk), .rst(rst), .start(start), .bus(bus0),
    .cpu_hold(cpu_hold0), .busy(busy0), .done(done0), .err(err0)
  );

  im_loader #(.IM_DEPTH(DEPTH), .ADDR_W(6), .BASE_ADDR(BASE1)) dut1 (
    .clk(clk), .rst(rst), .start(start), .bus(bus1),
    .cpu_hold(cpu_hold1), .busy(busy1), .done(done1), .err(err1)
  );

  // Write monitor: logs every strobe with the index of the negedge it was seen on.
  always @(negedge clk) begin
    if (bus0.im_we === 1'b1) act0.push_back('{cyc: neg_cnt, addr: bus0.im_waddr, data: bus0.im_wdata});
    if (bus1.im_we === 1'b1) act1.push_back('{cyc: neg_cnt, addr: bus1.im_waddr, data: bus1.im_wdata});
    neg_cnt <= neg_cnt + 1;
  end

  // Bytes the loader consumes: length, N payload bytes, plus the checksum when enabled.
  function automatic int stream_len(input bq_t s);
`ifdef IM_LOADER_CHECKSUM_EN
    return int'(s[0]) + 2;
`else
    return int'(s[0]) + 1;
`endif
  endfunction

  function automatic bit model_err(input int base, input bq_t s);
    int n;
    bit e;
    n = int'(s[0]);
    e = (n > 0) && (base + n > DEPTH);
`ifdef IM_LOADER_CHECKSUM_EN
    begin
      logic [7:0] sum;
      sum = 8'd0;
      for (int k = 0; k < n; k++) sum = sum + s[k+1];
      if (s[n+1] !== sum) e = 1'b1;
    end
`endif
    return e;
  endfunction

  // Starts a load and offers the first nsend bytes of s; returns on the negedge
  // after the last accepted byte. stall_mode: 0 none, 1 toggle, 2 random.
  task automatic send_stream(input bq_t s, input int nsend, input int stall_mode, input bit poke_start);
    int idx, waits, t, n;
    bit v;
    n = int'(s[0]);
    @(negedge clk);
    start = 1'b1;
    tb_valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
    #1;
    checks++;
    if (busy0 !== 1'b1 || cpu_hold0 !== 1'b1 || done0 !== 1'b0 || err0 !== 1'b0 || busy1 !== 1'b1) begin
      failures++;
      $display("FAIL start_accept: busy=%b hold=%b done=%b err=%b busy1=%b required 1 1 0 0 1",
               busy0, cpu_hold0, done0, err0, busy1);
    end
    idx = 0; waits = 0; t = 0;
    while (idx < nsend) begin
      case (stall_mode)
        1:       v = (t % 2) == 0;
        2:       v = ($urandom_range(0, 2) != 0);
        default: v = 1'b1;
      endcase
      t++;
      tb_valid = v;
      tb_data  = v ? s[idx] : 8'($urandom);
      start    = poke_start && ($urandom_range(0, 2) == 0);
      #1;
      if (tb_valid && bus0.in_ready === 1'b1) begin
        if (idx >= 1 && idx <= n) begin
          if (BASE0 + idx - 1 < DEPTH) exp0.push_back('{cyc: neg_cnt, addr: 6'(BASE0 + idx - 1), data: s[idx]});
          if (BASE1 + idx - 1 < DEPTH) exp1.push_back('{cyc: neg_cnt, addr: 6'(BASE1 + idx - 1), data: s[idx]});
        end
        idx++;
        waits = 0;
      end else begin
        waits++;
        if (waits > 40) begin
          checks++;
          failures++;
          $display("FAIL accept_timeout: byte %0d not accepted after %0d cycles, in_ready=%b required 1",
                   idx, waits, bus0.in_ready);
          start = 1'b0;
          tb_valid = 1'b0;
          return;
        end
      end
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  // Called on the negedge after the last accepted byte: checks the FIN cycle,
  // the completion one cycle later, and the full write log of both loaders.
  task automatic check_finish(input string name, input bit e0, input bit e1);
    tb_valid = 1'b1;
    tb_data  = 8'($urandom);
    #1;
    checks++;
    if (bus0.in_ready !== 1'b0 || done0 !== 1'b0 || busy0 !== 1'b1) begin
      failures++;
      $display("FAIL %s_fin: in_ready=%b done=%b busy=%b required 0 0 1", name, bus0.in_ready, done0, busy0);
    end
    @(negedge clk);
    #1;
    tb_valid = 1'b0;
    checks++;
    if (done0 !== 1'b1 || busy0 !== 1'b0 || cpu_hold0 !== 1'b0 || err0 !== e0) begin
      failures++;
      $display("FAIL %s_end0: done=%b busy=%b hold=%b err=%b required 1 0 0 %b", name, done0, busy0, cpu_hold0, err0, e0);
    end
    checks++;
    if (done1 !== 1'b1 || busy1 !== 1'b0 || cpu_hold1 !== 1'b0 || err1 !== e1) begin
      failures++;
      $display("FAIL %s_end1: done=%b busy=%b hold=%b err=%b required 1 0 0 %b", name, done1, busy1, cpu_hold1, err1, e1);
    end
    checks++;
    if (act0.size() != exp0.size() || act1.size() != exp1.size()) begin
      failures++;
      $display("FAIL %s_wcount: writes0=%0d writes1=%0d required %0d %0d", name, act0.size(), act1.size(), exp0.size(), exp1.size());
    end else begin
      for (int i = 0; i < exp0.size(); i++) begin
        checks++;
        if (act0[i] !== exp0[i]) begin
          failures++;
          $display("FAIL %s_w0[%0d]: cyc=%0d addr=%0d data=%h required cyc=%0d addr=%0d data=%h", name, i,
                   act0[i].cyc, act0[i].addr, act0[i].data, exp0[i].cyc, exp0[i].addr, exp0[i].data);
        end
      end
      for (int i = 0; i < exp1.size(); i++) begin
        checks++;
        if (act1[i] !== exp1[i]) begin
          failures++;
          $display("FAIL %s_w1[%0d]: cyc=%0d addr=%0d data=%h required cyc=%0d addr=%0d data=%h", name, i,
                   act1[i].cyc, act1[i].addr, act1[i].data, exp1[i].cyc, exp1[i].addr, exp1[i].data);
        end
      end
    end
    $display("load %s: writes0=%0d writes1=%0d err0=%b err1=%b done=%b", name, act0.size(), act1.size(), err0, err1, done0);
    act0.delete(); act1.delete(); exp0.delete(); exp1.delete();
  endtask

  task automatic run_load(input string name, input bq_t s, input int stall_mode, input bit poke_start);
    send_stream(s, stream_len(s), stall_mode, poke_start);
    check_finish(name, model_err(BASE0, s), model_err(BASE1, s));
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; tb_valid = 1'b0; tb_data = 8'h00;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (bus0.in_ready !== 1'b0 || bus0.im_we !== 1'b0 || bus0.im_waddr !== 6'd0 || bus0.im_wdata !== 8'd0 ||
        cpu_hold0 !== 1'b0 || busy0 !== 1'b0 || done0 !== 1'b0 || err0 !== 1'b0) begin
      failures++;
      $display("FAIL reset0: rdy=%b we=%b addr=%0d data=%h hold=%b busy=%b done=%b err=%b required all 0",
               bus0.in_ready, bus0.im_we, bus0.im_waddr, bus0.im_wdata, cpu_hold0, busy0, done0, err0);
    end
    checks++;
    if (bus1.in_ready !== 1'b0 || bus1.im_we !== 1'b0 || cpu_hold1 !== 1'b0 || busy1 !== 1'b0 ||
        done1 !== 1'b0 || err1 !== 1'b0) begin
      failures++;
      $display("FAIL reset1: rdy=%b we=%b hold=%b busy=%b done=%b err=%b required all 0",
               bus1.in_ready, bus1.im_we, cpu_hold1, busy1, done1, err1);
    end
    rst = 1'b0;
    $display("reset: outputs sampled");
  endtask

  task automatic test_basic();
    bq_t s;
    s = '{8'h03, 8'h38, 8'h01, 8'h01, 8'h3A};
    run_load("basic", s, 0, 1'b0);
  endtask

  task automatic test_stalls();
    bq_t s;
    s = '{8'h03, 8'h38, 8'h01, 8'h01, 8'h3A};
    run_load("stall_toggle", s, 1, 1'b0);
  endtask

  task automatic test_checksum();
    bq_t s;
    s = '{8'h02, 8'h10, 8'h20, 8'h30};
    run_load("csum_ok", s, 0, 1'b0);
    s = '{8'h02, 8'h10, 8'h20, 8'h31};
    run_load("csum_bad", s, 2, 1'b0);
  endtask

  task automatic test_zero_len();
    bq_t s;
    s = '{8'h00, 8'h00};
    run_load("zero_len", s, 0, 1'b1);
  endtask

  task automatic test_idle_ignore();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      tb_valid = 1'b1;
      tb_data  = 8'($urandom);
      #1;
      checks++;
      if (bus0.in_ready !== 1'b0) begin
        failures++;
        $display("FAIL idle_ready: in_ready=%b required 0", bus0.in_ready);
      end
    end
    @(negedge clk);
    tb_valid = 1'b0;
    #1;
    checks++;
    if (act0.size() != 0 || act1.size() != 0 || busy0 !== 1'b0) begin
      failures++;
      $display("FAIL idle_ignore: writes0=%0d writes1=%0d busy=%b required 0 0 0", act0.size(), act1.size(), busy0);
    end
    $display("idle: stream offered in IDLE, writes0=%0d", act0.size());
  endtask

  task automatic test_reset_mid_load();
    bq_t s;
    s = '{8'h05, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'hFF};
    send_stream(s, 3, 0, 1'b0);
    rst = 1'b1;
    tb_valid = 1'b1;
    tb_data = 8'h33;
    @(negedge clk);
    #1;
    checks++;
    if (bus0.in_ready !== 1'b0 || bus0.im_we !== 1'b0 || bus0.im_waddr !== 6'd0 || bus0.im_wdata !== 8'd0 ||
        cpu_hold0 !== 1'b0 || busy0 !== 1'b0 || done0 !== 1'b0 || err0 !== 1'b0 ||
        bus1.im_we !== 1'b0 || busy1 !== 1'b0 || err1 !== 1'b0) begin
      failures++;
      $display("FAIL midload_reset: rdy=%b we=%b addr=%0d data=%h hold=%b busy=%b done=%b err=%b we1=%b busy1=%b err1=%b required all 0",
               bus0.in_ready, bus0.im_we, bus0.im_waddr, bus0.im_wdata, cpu_hold0, busy0, done0, err0,
               bus1.im_we, busy1, err1);
    end
    rst = 1'b0;
    tb_valid = 1'b0;
    s = '{8'h01, 8'hAA, 8'hAA};
    run_load("after_reset", s, 0, 1'b0);
  endtask

  task automatic test_random();
    bq_t s;
    int n;
    logic [7:0] sum;
    for (int it = 0; it < 16; it++) begin
      s.delete();
      n = $urandom_range(0, 10);
      s.push_back(8'(n));
      sum = 8'd0;
      for (int k = 0; k < n; k++) begin
        s.push_back(8'($urandom));
        sum = sum + s[k+1];
      end
      s.push_back(($urandom_range(0, 1) == 0) ? sum : sum + 8'(1 + $urandom_range(0, 254)));
      run_load($sformatf("rand%0d_n%0d", it, n), s, 2, ($urandom_range(0, 1) == 1));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_idle_ignore();
    test_basic();
    test_stalls();
    test_checksum();
    test_zero_len();
    test_reset_mid_load();
    test_random();
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
